// File: rtl/uart_pkg.sv
// Shared types and constants for the UART packet framing stage.
// State and error encodings are visible on debug/status ports, so values are pinned.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StCmd     = 3'd1,
    StLen     = 3'd2,
    StPayload = 3'd3,
    StChk     = 3'd4,
    StResp    = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ErrNone    = 2'd0,
    ErrChk     = 2'd1,
    ErrLen     = 2'd2,
    ErrTimeout = 2'd3
  } err_e;

  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NACK_BYTE = 8'h15;

  // States in which a packet is open and the inter-byte timer must run.
  function automatic logic in_packet(input state_e s);
    return (s == StCmd) || (s == StLen) || (s == StPayload) || (s == StChk);
  endfunction

endpackage

// File: rtl/byte_timeout.sv
// Loadable up-counter that saturates at 'limit' and flags expiry while enabled.
// Clear has priority over load, load over counting.
module byte_timeout #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic [Width-1:0] limit,
  output logic             expired
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != limit)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = en && (cnt_q == limit);

endmodule

// File: rtl/uart_packet_parser.sv
// Delimits SOF/CMD/LEN/payload/CHK packets from the UART RX byte stream, forwards payload
// bytes speculatively and queues a one-byte ACK/NACK for the UART TX path.
module uart_packet_parser
  import uart_pkg::*;
#(
  parameter int unsigned CLK_F      = 50_000_000,
  parameter int unsigned TIMEOUT_US = 2000,
  parameter int unsigned MAX_LEN    = 16,
  parameter logic [7:0]  SOF_BYTE   = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  output logic [7:0] o_payload_data,
  output logic       o_payload_valid,
  output logic [7:0] o_payload_idx,
  output logic       o_pkt_done,
  output logic       o_pkt_ok,
  output logic [7:0] o_pkt_cmd,
  output logic [7:0] o_pkt_len,
  output logic [7:0] o_tx_data,
  output logic       o_tx_valid,
  input  logic       i_tx_full,
  output logic [2:0] o_state,
  output logic [1:0] o_err_code
);

  // 64-bit product: the default clock times microseconds overflows 32 bits.
  localparam longint unsigned TimeoutCycL =
      (64'(CLK_F) * 64'(TIMEOUT_US)) / 64'd1_000_000;
  localparam int unsigned TIMEOUT_CYC = 32'(TimeoutCycL);
  localparam logic [31:0] TimeoutLimit = 32'(TIMEOUT_CYC - 1);
  localparam logic [7:0]  MaxLenB      = 8'(MAX_LEN);

  state_e     state_q;
  err_e       err_q;
  logic [7:0] chk_q;
  logic [7:0] idx_q;
  logic [7:0] payload_data_q;
  logic       payload_valid_q;
  logic [7:0] payload_idx_q;
  logic       pkt_done_q;
  logic       pkt_ok_q;
  logic [7:0] pkt_cmd_q;
  logic [7:0] pkt_len_q;
  logic [7:0] tx_data_q;
  logic       tx_valid_q;

  logic tmo_expired;
  logic tmo_hit;
  logic tmo_en;
  logic tmo_clr;

  // An arriving byte always beats a simultaneous expiry.
  assign tmo_en  = in_packet(state_q);
  assign tmo_hit = tmo_expired && !i_rx_valid;
  assign tmo_clr = i_rx_valid || tmo_hit;

  byte_timeout #(
    .Width (32)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmo_clr),
    .en       (tmo_en),
    .load     (1'b0),
    .load_val (32'd0),
    .limit    (TimeoutLimit),
    .expired  (tmo_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StIdle;
      err_q           <= ErrNone;
      chk_q           <= 8'h00;
      idx_q           <= 8'h00;
      payload_data_q  <= 8'h00;
      payload_valid_q <= 1'b0;
      payload_idx_q   <= 8'h00;
      pkt_done_q      <= 1'b0;
      pkt_ok_q        <= 1'b0;
      pkt_cmd_q       <= 8'h00;
      pkt_len_q       <= 8'h00;
      tx_data_q       <= 8'h00;
      tx_valid_q      <= 1'b0;
    end else begin
      payload_valid_q <= 1'b0;
      pkt_done_q      <= 1'b0;
      tx_valid_q      <= 1'b0;

      if (tmo_hit) begin
        state_q    <= StIdle;
        err_q      <= ErrTimeout;
        pkt_done_q <= 1'b1;
        pkt_ok_q   <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (i_rx_valid && (i_rx_data == SOF_BYTE)) begin
              state_q <= StCmd;
              chk_q   <= 8'h00;
            end
          end
          StCmd: begin
            if (i_rx_valid) begin
              pkt_cmd_q <= i_rx_data;
              chk_q     <= i_rx_data;
              state_q   <= StLen;
            end
          end
          StLen: begin
            if (i_rx_valid) begin
              pkt_len_q <= i_rx_data;
              chk_q     <= chk_q ^ i_rx_data;
              idx_q     <= 8'h00;
              if (i_rx_data > MaxLenB) begin
                tx_data_q  <= NACK_BYTE;
                err_q      <= ErrLen;
                pkt_done_q <= 1'b1;
                pkt_ok_q   <= 1'b0;
                state_q    <= StResp;
              end else if (i_rx_data == 8'h00) begin
                state_q <= StChk;
              end else begin
                state_q <= StPayload;
              end
            end
          end
          StPayload: begin
            if (i_rx_valid) begin
              payload_data_q  <= i_rx_data;
              payload_valid_q <= 1'b1;
              payload_idx_q   <= idx_q;
              idx_q           <= idx_q + 8'd1;
              chk_q           <= chk_q ^ i_rx_data;
              if (idx_q == (pkt_len_q - 8'd1)) begin
                state_q <= StChk;
              end
            end
          end
          StChk: begin
            if (i_rx_valid) begin
              pkt_done_q <= 1'b1;
              state_q    <= StResp;
              if (i_rx_data == chk_q) begin
                tx_data_q <= ACK_BYTE;
                pkt_ok_q  <= 1'b1;
                err_q     <= ErrNone;
              end else begin
                tx_data_q <= NACK_BYTE;
                pkt_ok_q  <= 1'b0;
                err_q     <= ErrChk;
              end
            end
          end
          StResp: begin
            // Incoming bytes are dropped here; the RX FIFO upstream holds them.
            if (!i_tx_full) begin
              tx_valid_q <= 1'b1;
              state_q    <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign o_payload_data  = payload_data_q;
  assign o_payload_valid = payload_valid_q;
  assign o_payload_idx   = payload_idx_q;
  assign o_pkt_done      = pkt_done_q;
  assign o_pkt_ok        = pkt_ok_q;
  assign o_pkt_cmd       = pkt_cmd_q;
  assign o_pkt_len       = pkt_len_q;
  assign o_tx_data       = tx_data_q;
  assign o_tx_valid      = tx_valid_q;
  assign o_state         = state_q;
  assign o_err_code      = err_q;

endmodule

// File: tb/tb_uart_packet_parser.sv
// Scoreboard bench for uart_packet_parser: scenario tasks push expected outputs while
// driving bytes; a negedge monitor pops and compares them as the DUT emits them.
module tb_uart_packet_parser;

  localparam int unsigned TimeoutCyc = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] i_rx_data;
  logic       i_rx_valid;
  logic       i_tx_full;
  logic [7:0] o_payload_data;
  logic       o_payload_valid;
  logic [7:0] o_payload_idx;
  logic       o_pkt_done;
  logic       o_pkt_ok;
  logic [7:0] o_pkt_cmd;
  logic [7:0] o_pkt_len;
  logic [7:0] o_tx_data;
  logic       o_tx_valid;
  logic [2:0] o_state;
  logic [1:0] o_err_code;

  always #5 clk = ~clk;

  uart_packet_parser #(
    .CLK_F      (1_000_000),
    .TIMEOUT_US (TimeoutCyc),
    .MAX_LEN    (16),
    .SOF_BYTE   (8'hA5)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_rx_data       (i_rx_data),
    .i_rx_valid      (i_rx_valid),
    .o_payload_data  (o_payload_data),
    .o_payload_valid (o_payload_valid),
    .o_payload_idx   (o_payload_idx),
    .o_pkt_done      (o_pkt_done),
    .o_pkt_ok        (o_pkt_ok),
    .o_pkt_cmd       (o_pkt_cmd),
    .o_pkt_len       (o_pkt_len),
    .o_tx_data       (o_tx_data),
    .o_tx_valid      (o_tx_valid),
    .i_tx_full       (i_tx_full),
    .o_state         (o_state),
    .o_err_code      (o_err_code)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_tx     = 0;

  // {data, idx}, {ok, cmd, len, err}, tx byte
  logic [15:0] exp_pl[$];
  logic [18:0] exp_done[$];
  logic [7:0]  exp_tx[$];
  logic [15:0] pl_e;
  logic [18:0] done_e;
  logic [7:0]  tx_e;
  logic        rx_seen = 1'b0;

  always @(posedge clk) rx_seen <= i_rx_valid;

  always @(negedge clk) begin
    if (!rst) begin
      if (o_payload_valid) begin
        n_checks++;
        if (exp_pl.size() == 0) begin
          $display("FAIL payload_unexpected got data=%h idx=%0d want none", o_payload_data,
                   o_payload_idx);
        end else begin
          pl_e = exp_pl.pop_front();
          if ({o_payload_data, o_payload_idx} !== pl_e)
            $display("FAIL payload got data=%h idx=%0d want data=%h idx=%0d", o_payload_data,
                     o_payload_idx, pl_e[15:8], pl_e[7:0]);
          else n_pass++;
        end
        n_checks++;
        if (rx_seen !== 1'b1) $display("FAIL payload_latency got late strobe want 1 cycle");
        else n_pass++;
      end
      if (o_pkt_done) begin
        n_checks++;
        if (exp_done.size() == 0) begin
          $display("FAIL done_unexpected got ok=%b err=%0d want none", o_pkt_ok, o_err_code);
        end else begin
          done_e = exp_done.pop_front();
          if ({o_pkt_ok, o_pkt_cmd, o_pkt_len, o_err_code} !== done_e)
            $display("FAIL done got ok=%b cmd=%h len=%h err=%0d want ok=%b cmd=%h len=%h err=%0d",
                     o_pkt_ok, o_pkt_cmd, o_pkt_len, o_err_code, done_e[18], done_e[17:10],
                     done_e[9:2], done_e[1:0]);
          else n_pass++;
        end
      end
      if (o_tx_valid) begin
        n_tx++;
        n_checks++;
        if (exp_tx.size() == 0) begin
          $display("FAIL tx_unexpected got %h want none", o_tx_data);
        end else begin
          tx_e = exp_tx.pop_front();
          if (o_tx_data !== tx_e) $display("FAIL tx_byte got %h want %h", o_tx_data, tx_e);
          else n_pass++;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(negedge clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_pl.size() == 0 && exp_done.size() == 0 && exp_tx.size() == 0 && o_state == 3'd0)
      begin
        ok = 1'b1;
        break;
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    i_rx_data  = 8'h00;
    i_rx_valid = 1'b0;
    i_tx_full  = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({o_payload_valid, o_pkt_done, o_pkt_ok, o_tx_valid} !== 4'b0)
      $display("FAIL reset_strobes got %b want 0000",
               {o_payload_valid, o_pkt_done, o_pkt_ok, o_tx_valid});
    else n_pass++;
    n_checks++;
    if ({o_payload_data, o_payload_idx, o_pkt_cmd, o_pkt_len, o_tx_data} !== 40'h0)
      $display("FAIL reset_data got %h want 0",
               {o_payload_data, o_payload_idx, o_pkt_cmd, o_pkt_len, o_tx_data});
    else n_pass++;
    n_checks++;
    if ({o_state, o_err_code} !== 5'b0)
      $display("FAIL reset_state got state=%0d err=%0d want 0 0", o_state, o_err_code);
    else n_pass++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_valid_packet();
    bit ok;
    exp_pl.push_back({8'h11, 8'd0});
    exp_pl.push_back({8'h22, 8'd1});
    exp_pl.push_back({8'h33, 8'd2});
    exp_done.push_back({1'b1, 8'h10, 8'h03, 2'd0});
    exp_tx.push_back(8'h06);
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h13);
    wait_idle(50, ok);
    n_checks++;
    if (!ok) $display("FAIL valid_drain got pending outputs want all seen");
    else n_pass++;
  endtask

  task automatic test_checksum_error();
    bit ok;
    exp_pl.push_back({8'h11, 8'd0});
    exp_pl.push_back({8'h22, 8'd1});
    exp_pl.push_back({8'h33, 8'd2});
    exp_done.push_back({1'b0, 8'h10, 8'h03, 2'd1});
    exp_tx.push_back(8'h15);
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h14);
    wait_idle(50, ok);
    n_checks++;
    if (!ok) $display("FAIL chk_drain got pending outputs want all seen");
    else n_pass++;
    n_checks++;
    if (o_err_code !== 2'd1) $display("FAIL chk_err_code got %0d want 1", o_err_code);
    else n_pass++;
  endtask

  task automatic test_length_error();
    bit ok;
    exp_done.push_back({1'b0, 8'h20, 8'h11, 2'd2});
    exp_tx.push_back(8'h15);
    send_byte(8'hA5); send_byte(8'h20); send_byte(8'h11);
    wait_idle(50, ok);
    n_checks++;
    if (!ok) $display("FAIL len_drain got pending outputs want all seen");
    else n_pass++;
    n_checks++;
    if (o_err_code !== 2'd2) $display("FAIL len_err_code got %0d want 2", o_err_code);
    else n_pass++;
    // Next packet after a length error must parse normally.
    exp_pl.push_back({8'hAA, 8'd0});
    exp_done.push_back({1'b1, 8'h01, 8'h01, 2'd0});
    exp_tx.push_back(8'h06);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01); send_byte(8'hAA); send_byte(8'hAA);
    wait_idle(50, ok);
    n_checks++;
    if (!ok) $display("FAIL len_recover got pending outputs want all seen");
    else n_pass++;
  endtask

  task automatic test_zero_len_junk();
    bit ok;
    exp_done.push_back({1'b1, 8'h07, 8'h00, 2'd0});
    exp_tx.push_back(8'h06);
    send_byte(8'h00); send_byte(8'hFF);
    send_byte(8'hA5); send_byte(8'h07); send_byte(8'h00); send_byte(8'h07);
    wait_idle(50, ok);
    n_checks++;
    if (!ok) $display("FAIL zero_drain got pending outputs want all seen");
    else n_pass++;
  endtask

  task automatic test_timeout();
    bit ok;
    int tx_before;
    tx_before = n_tx;
    exp_pl.push_back({8'h11, 8'd0});
    exp_done.push_back({1'b0, 8'h10, 8'h02, 2'd3});
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02); send_byte(8'h11);
    wait_idle(TimeoutCyc + 30, ok);
    n_checks++;
    if (!ok) $display("FAIL timeout_drain got no timeout done want done within budget");
    else n_pass++;
    n_checks++;
    if (o_state !== 3'd0) $display("FAIL timeout_state got %0d want 0", o_state);
    else n_pass++;
    n_checks++;
    if (o_err_code !== 2'd3) $display("FAIL timeout_err_code got %0d want 3", o_err_code);
    else n_pass++;
    n_checks++;
    if (n_tx !== tx_before) $display("FAIL timeout_no_tx got %0d tx want 0", n_tx - tx_before);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    bit ok;
    bit reached;
    int tx_before;
    i_tx_full = 1'b1;
    exp_pl.push_back({8'h55, 8'd0});
    exp_done.push_back({1'b1, 8'h03, 8'h01, 2'd0});
    exp_tx.push_back(8'h06);
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h01); send_byte(8'h55); send_byte(8'h57);
    reached = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (o_state == 3'd5) begin
        reached = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!reached) $display("FAIL bp_resp got state=%0d want 5", o_state);
    else n_pass++;
    tx_before = n_tx;
    repeat (50) @(negedge clk);
    n_checks++;
    if (n_tx !== tx_before) $display("FAIL bp_held got %0d tx want 0", n_tx - tx_before);
    else n_pass++;
    i_tx_full = 1'b0;
    wait_idle(20, ok);
    n_checks++;
    if (n_tx !== tx_before + 1) $display("FAIL bp_release got %0d tx want 1", n_tx - tx_before);
    else n_pass++;
  endtask

  task automatic test_reset_mid_packet();
    int tx_before;
    exp_pl.push_back({8'h11, 8'd0});
    exp_pl.push_back({8'h22, 8'd1});
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({o_payload_valid, o_pkt_done, o_pkt_ok, o_tx_valid, o_state, o_err_code} !== 9'b0)
      $display("FAIL midrst_ctrl got %b want 0",
               {o_payload_valid, o_pkt_done, o_pkt_ok, o_tx_valid, o_state, o_err_code});
    else n_pass++;
    n_checks++;
    if ({o_payload_data, o_payload_idx, o_pkt_cmd, o_pkt_len, o_tx_data} !== 40'h0)
      $display("FAIL midrst_data got %h want 0",
               {o_payload_data, o_payload_idx, o_pkt_cmd, o_pkt_len, o_tx_data});
    else n_pass++;
    exp_pl.delete();
    @(negedge clk);
    rst = 1'b0;
    tx_before = n_tx;
    repeat (30) @(negedge clk);
    n_checks++;
    if (n_tx !== tx_before) $display("FAIL midrst_no_tx got %0d tx want 0", n_tx - tx_before);
    else n_pass++;
    n_checks++;
    if (o_state !== 3'd0) $display("FAIL midrst_state got %0d want 0", o_state);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_valid_packet();
    test_checksum_error();
    test_length_error();
    test_zero_len_junk();
    test_timeout();
    test_backpressure();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_packet_parser.md
Name: uart_packet_parser

Overview:
Framing stage directly downstream of the UART RX FIFO and upstream of the UART TX path. It consumes the received byte stream and delimits packets of the form SOF, CMD, LEN, payload[LEN], CHK. Payload bytes are forwarded to the system side, and a one-byte ACK/NACK is returned through the UART TX interface. An inter-byte timeout recovers the parser from truncated packets.

Parameters:
CLK_F, 50_000_000, system clock frequency in Hz.
TIMEOUT_US, 2000, maximum gap between bytes inside a packet, in µs. Converted to TIMEOUT_CYC = CLK_F*TIMEOUT_US/1e6 at elaboration.
MAX_LEN, 16, largest accepted payload length. Must be ≤ 255.
SOF_BYTE, 8'hA5, start-of-frame marker.

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
i_rx_data  in  8  byte from UART RX FIFO
i_rx_valid  in  1  one-cycle strobe: i_rx_data is valid
o_payload_data  out  8  forwarded payload byte
o_payload_valid  out  1  one-cycle strobe per payload byte
o_payload_idx  out  8  index of the current payload byte, 0..LEN-1
o_pkt_done  out  1  one-cycle strobe at packet end
o_pkt_ok  out  1  packet status, qualified by o_pkt_done
o_pkt_cmd  out  8  CMD of the last packet; held until the next packet
o_pkt_len  out  8  LEN of the last packet; held until the next packet
o_tx_data  out  8  response byte to UART TX
o_tx_valid  out  1  one-cycle write strobe to UART TX
i_tx_full  in  1  UART TX FIFO full
o_state  out  3  FSM state, for debug
o_err_code  out  2  cause of the last error: 0 none, 1 checksum, 2 length, 3 timeout

Behaviour:
- Reset (asynchronous assert, synchronous-to-clk deassert): state IDLE. All outputs 0. o_err_code 0. Checksum, counters and pending response are cleared. Reset mid-packet abandons the packet; no response is sent.
- FSM states: IDLE(0), CMD(1), LEN(2), PAYLOAD(3), CHK(4), RESP(5).
- IDLE: on i_rx_valid with data == SOF_BYTE, go to CMD and clear the checksum. Any other byte is silently discarded.
- CMD: latch the CMD byte, set chk = CMD, go to LEN.
- LEN: latch LEN, chk ^= LEN.
  - LEN > MAX_LEN: go to RESP with NACK, err_code 2, o_pkt_done with o_pkt_ok=0.
  - LEN == 0: go to CHK.
  - Otherwise: go to PAYLOAD.
- PAYLOAD: each byte is forwarded with chk ^= byte.
  - o_payload_valid, o_payload_data and o_payload_idx are registered and appear exactly 1 cycle after i_rx_valid.
  - The index counter increments per byte. After byte LEN-1, go to CHK.
  - No backpressure: the downstream must accept every strobe.
  - Payload is forwarded speculatively. The consumer discards it if o_pkt_ok=0.
- CHK: compare the byte with chk.
  - Match: ACK 8'h06, o_pkt_ok=1, err_code 0.
  - Mismatch: NACK 8'h15, o_pkt_ok=0, err_code 1.
  - o_pkt_done pulses 1 cycle after the CHK byte strobe. Go to RESP.
- RESP: on the first cycle with i_tx_full=0, pulse o_tx_valid for 1 cycle with o_tx_data held, then go to IDLE.
  - If i_tx_full is high, wait indefinitely; o_tx_valid stays low.
  - Bytes arriving during RESP are dropped. The UART RX FIFO absorbs them upstream.
- Timeout: a counter runs in CMD, LEN, PAYLOAD and CHK, and is cleared on every i_rx_valid.
  - When it reaches TIMEOUT_CYC-1: go to IDLE, set err_code 3, pulse o_pkt_done with o_pkt_ok=0. No TX response is sent.
  - If i_rx_valid and expiry occur in the same cycle, the byte wins and the counter clears.
  - The counter is frozen in IDLE and RESP.
- A SOF_BYTE value inside a packet is ordinary data; there is no resynchronisation mid-packet.
- o_pkt_done and o_tx_valid never assert in the same cycle as o_payload_valid for the same packet.

Decomposition:
- Package uart_pkg holds:
  - the state enum typedef (3-bit);
  - ACK_BYTE = 8'h06 and NACK_BYTE = 8'h15;
  - the err_code enum.
- One sub-module, byte_timeout: a loadable counter with clear and enable inputs and an expired output. It is reused later for TX pacing.

Test Plan:
1. Valid packet: A5 10 03 11 22 33 CHK=10^03^11^22^33=0x13 -> 3 payload strobes (idx 0,1,2; data 11,22,33); o_pkt_done with ok=1, cmd=0x10, len=3; o_tx_valid with 0x06.
2. Checksum error: same packet with CHK=0x14 -> payload forwarded; done with ok=0; err_code=1; TX 0x15.
3. Length error: A5 20 11 (LEN 17 > 16) -> no payload strobes; done with ok=0; err_code=2; TX 0x15; the next A5 is parsed normally.
4. Zero length plus junk: 00 FF A5 07 00 07 -> junk ignored; done with ok=1, len=0; TX 0x06.
5. Timeout: A5 10 02 11, then no byte for TIMEOUT_CYC cycles -> done with ok=0; err_code=3; no o_tx_valid; state returns to IDLE.
6. Backpressure and reset: hold i_tx_full=1 during RESP for 50 cycles, then release -> exactly one o_tx_valid. Separately, assert rst in the middle of PAYLOAD -> all outputs 0 immediately and no response.
